// File: rtl/ccd_fifo_writer_if.sv
// ccd_fifo_writer_if: pixel stream in from capture, packed-word write strobe out to the CCD FIFO.
interface ccd_fifo_writer_if;
    logic        iFVAL;
    logic        iDVAL;
    logic [9:0]  iRed;
    logic [9:0]  iGreen;
    logic [9:0]  iBlue;
    logic        iFIFO_FULL;
    logic        CCD_FIFO_WE;
    logic [29:0] CCD_FIFO_IN;
    modport master (input iFVAL, iDVAL, iRed, iGreen, iBlue, iFIFO_FULL, output CCD_FIFO_WE, CCD_FIFO_IN);
    modport slave (output iFVAL, iDVAL, iRed, iGreen, iBlue, iFIFO_FULL, input CCD_FIFO_WE, CCD_FIFO_IN);
endinterface

// File: rtl/ccd_fifo_writer.sv
// ccd_fifo_writer: frames the RGB pixel stream into the CCD FIFO, tracking position,
// completed frames and overflow, and dropping the rest of a frame once a pixel is lost.
module ccd_fifo_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic                      CCD_FIFO_WRCLK,
    input  logic                      iRST_N,
    input  logic                      iSTART,
    input  logic                      iCONT,
    ccd_fifo_writer_if.master         bus,
    output logic [9:0]                oX_CNT,
    output logic [8:0]                oY_CNT,
    output logic [15:0]               oFRAME_CNT,
    output logic                      oOVERFLOW,
    output logic                      oBUSY
);
    typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DROP} state_t;
    state_t      state_q;
    logic        fval_q, we_q, ovf_q;
    logic [29:0] din_q;
    logic [9:0]  x_q, x_base, x_d;
    logic [8:0]  y_q, y_base, y_d;
    logic [15:0] frame_q;
    logic        sof, eof, arm_sof, accept, write, lost, x_wrap;
    assign sof     = bus.iFVAL & ~fval_q;
    assign eof     = ~bus.iFVAL & fval_q;
    assign arm_sof = state_q == WAIT_SOF && sof;
    // The SOF cycle already counts as ACTIVE, with counters seen as freshly cleared.
    assign x_base  = arm_sof ? '0 : x_q;
    assign y_base  = arm_sof ? '0 : y_q;
    assign accept  = (state_q == ACTIVE || arm_sof) && bus.iFVAL && bus.iDVAL && y_base < 9'(V_ACTIVE);
    assign write   = accept & ~bus.iFIFO_FULL;
    assign lost    = accept & bus.iFIFO_FULL;
    assign x_wrap  = x_base == 10'(H_ACTIVE - 1);
    assign x_d     = write ? (x_wrap ? '0 : x_base + 10'd1) : x_base;
    assign y_d     = write && x_wrap ? y_base + 9'd1 : y_base;
    always_ff @(posedge CCD_FIFO_WRCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            fval_q  <= 1'b0;
            we_q    <= 1'b0;
            din_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            fval_q <= bus.iFVAL;
            we_q   <= write;
            x_q    <= x_d;
            y_q    <= y_d;
            if (write)
                din_q <= {bus.iRed, bus.iGreen, bus.iBlue};
            if (lost) begin
                ovf_q   <= 1'b1;
                state_q <= DROP;
            end else begin
                case (state_q)
                    IDLE: if (iSTART) begin
                        ovf_q   <= 1'b0;
                        state_q <= WAIT_SOF;
                    end
                    WAIT_SOF: if (sof) state_q <= ACTIVE;
                    ACTIVE: if (eof) begin
                        if (y_q == 9'(V_ACTIVE))
                            frame_q <= frame_q + 16'd1;
                        state_q <= iCONT ? WAIT_SOF : IDLE;
                    end
                    DROP: if (eof) state_q <= iCONT ? WAIT_SOF : IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign bus.CCD_FIFO_WE = we_q;
    assign bus.CCD_FIFO_IN = din_q;
    assign oX_CNT          = x_q;
    assign oY_CNT          = y_q;
    assign oFRAME_CNT      = frame_q;
    assign oOVERFLOW       = ovf_q;
    assign oBUSY           = state_q != IDLE;
endmodule

// File: tb/tb_ccd_fifo_writer.sv
// tb_ccd_fifo_writer: directed table plus hand sequences for the CCD FIFO writer
// with a 4x2 active window.
module tb_ccd_fifo_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [9:0]  x_cnt;
    logic [8:0]  y_cnt;
    logic [15:0] frame_cnt;
    logic        ovf, busy;
    int          checks = 0;
    int          fails = 0;
    int          wr_cnt = 0;

    ccd_fifo_writer_if bus ();

    ccd_fifo_writer #(.H_ACTIVE(4), .V_ACTIVE(2)) dut (
        .CCD_FIFO_WRCLK(clk),
        .iRST_N(rst_n),
        .iSTART(start),
        .iCONT(cont),
        .bus(bus.master),
        .oX_CNT(x_cnt),
        .oY_CNT(y_cnt),
        .oFRAME_CNT(frame_cnt),
        .oOVERFLOW(ovf),
        .oBUSY(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start, fval, dval, full;
        logic [9:0]  pix;
        logic        e_we;
        logic [29:0] e_din;
        int          e_x, e_y, e_frame;
        logic        e_ovf, e_busy;
    } vec_t;

    vec_t v[13];

    function automatic logic [29:0] pk(input int n);
        pk = {10'(n), 10'(n), 10'(n)};
    endfunction

    function automatic vec_t mk(input logic s, fv, dv, fl, input int p, input logic we, input int dn,
                                input int x, y, fr, input logic ov, bz);
        mk = '{s, fv, dv, fl, 10'(p), we, pk(dn), x, y, fr, ov, bz};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, dv, fl, input int p);
        bus.iFVAL = fv;
        bus.iDVAL = dv;
        bus.iFIFO_FULL = fl;
        bus.iRed = 10'(p);
        bus.iGreen = 10'(p);
        bus.iBlue = 10'(p);
    endtask

    // SOF, n pixels valued 0..n-1 (full on index full_at), a blank cycle, EOF, one idle cycle
    task automatic frame(input int n, input int full_at);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, i == full_at, i);
            tick;
        end
        drive(1'b1, 1'b0, 1'b0, 0);
        tick;
        drive(1'b0, 1'b0, 1'b0, 0);
        tick;
        tick;
    endtask

    // Each frame in this bench sends pixels 0,1,2..., so the k-th write of a frame carries k.
    always @(negedge clk) begin
        if (bus.CCD_FIFO_WE === 1'b1) begin
            chk("write_data", bus.CCD_FIFO_IN, pk(wr_cnt));
            wr_cnt++;
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 0);
        //      st fv dv fl pix we din x  y  fr ov bz
        v[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        v[1]  = mk(0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1);
        v[2]  = mk(0, 1, 1, 0, 1, 1, 1, 2, 0, 0, 0, 1);
        v[3]  = mk(0, 1, 1, 0, 2, 1, 2, 3, 0, 0, 0, 1);
        v[4]  = mk(0, 1, 1, 0, 3, 1, 3, 0, 1, 0, 0, 1);
        v[5]  = mk(0, 1, 1, 0, 4, 1, 4, 1, 1, 0, 0, 1);
        v[6]  = mk(0, 1, 1, 0, 5, 1, 5, 2, 1, 0, 0, 1);
        v[7]  = mk(0, 1, 1, 0, 6, 1, 6, 3, 1, 0, 0, 1);
        v[8]  = mk(0, 1, 1, 0, 7, 1, 7, 0, 2, 0, 0, 1);
        v[9]  = mk(0, 1, 0, 0, 0, 0, 7, 0, 2, 0, 0, 1);
        v[10] = mk(0, 0, 0, 0, 0, 0, 7, 0, 2, 1, 0, 0);
        v[11] = mk(0, 0, 1, 0, 9, 0, 7, 0, 2, 1, 0, 0);
        v[12] = mk(0, 0, 1, 1, 9, 0, 7, 0, 2, 1, 0, 0);

        tick;
        tick;
        chk("reset_we", bus.CCD_FIFO_WE, 0);
        chk("reset_din", bus.CCD_FIFO_IN, 0);
        chk("reset_x", x_cnt, 0);
        chk("reset_y", y_cnt, 0);
        chk("reset_frame", frame_cnt, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 13; i++) begin
            start = v[i].start;
            drive(v[i].fval, v[i].dval, v[i].full, int'(v[i].pix));
            tick;
            chk($sformatf("row%0d_we", i), bus.CCD_FIFO_WE, v[i].e_we);
            chk($sformatf("row%0d_din", i), bus.CCD_FIFO_IN, v[i].e_din);
            chk($sformatf("row%0d_x", i), x_cnt, v[i].e_x);
            chk($sformatf("row%0d_y", i), y_cnt, v[i].e_y);
            chk($sformatf("row%0d_frame", i), frame_cnt, v[i].e_frame);
            chk($sformatf("row%0d_ovf", i), ovf, v[i].e_ovf);
            chk($sformatf("row%0d_busy", i), busy, v[i].e_busy);
        end
        start = 1'b0;
        chk("single_frame_writes", wr_cnt, 8);

        // Mid-frame arm: no writes until the next SOF
        wr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            start = i == 1;
            drive(1'b1, 1'b1, 1'b0, i);
            tick;
        end
        start = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0);
        tick;
        chk("midarm_no_writes", wr_cnt, 0);
        chk("midarm_busy", busy, 1);
        frame(8, -1);
        chk("midarm_writes", wr_cnt, 8);
        chk("midarm_frame", frame_cnt, 2);
        chk("midarm_idle", busy, 0);

        // Overflow on pixel 5 with continuous mode
        cont = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, i == 4, i);
            tick;
        end
        chk("ovf_same_cycle", ovf, 1);
        for (int i = 5; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, i);
            tick;
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        tick;
        tick;
        chk("ovf_writes", wr_cnt, 4);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_frame", frame_cnt, 2);
        chk("ovf_x_frozen", x_cnt, 0);
        chk("ovf_y_frozen", y_cnt, 1);
        chk("ovf_rearmed", busy, 1);
        wr_cnt = 0;
        frame(8, -1);
        chk("ovf_next_writes", wr_cnt, 8);
        chk("ovf_next_frame", frame_cnt, 3);

        // Empty frame back to IDLE, then re-arm to clear overflow
        cont = 1'b0;
        frame(0, -1);
        chk("empty_frame_idle", busy, 0);
        chk("empty_frame_count", frame_cnt, 3);
        cont = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_clears_ovf", ovf, 0);

        // Excess then short frame
        wr_cnt = 0;
        frame(10, -1);
        chk("excess_writes", wr_cnt, 8);
        chk("excess_frame", frame_cnt, 4);
        chk("excess_y", y_cnt, 2);
        wr_cnt = 0;
        frame(5, -1);
        chk("short_writes", wr_cnt, 5);
        chk("short_frame", frame_cnt, 4);
        chk("short_ovf", ovf, 0);
        chk("short_x", x_cnt, 1);
        chk("short_y", y_cnt, 1);

        // Stray strobes: DVAL without FVAL, START while ACTIVE
        wr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 9);
            tick;
        end
        chk("stray_dval_writes", wr_cnt, 0);
        chk("stray_dval_x", x_cnt, 1);
        chk("stray_dval_ovf", ovf, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, i);
            tick;
        end
        start = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 0);
        tick;
        start = 1'b0;
        tick;
        chk("stray_start_writes", wr_cnt, 2);
        chk("stray_start_x", x_cnt, 2);
        chk("stray_start_y", y_cnt, 0);
        chk("stray_start_ovf", ovf, 0);
        chk("stray_start_busy", busy, 1);
        drive(1'b0, 1'b0, 1'b0, 0);
        tick;
        tick;

        // Reset after pixel 3 of a frame
        wr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, i);
            tick;
        end
        rst_n = 1'b0;
        #2;
        chk("async_rst_we", bus.CCD_FIFO_WE, 0);
        chk("async_rst_din", bus.CCD_FIFO_IN, 0);
        chk("async_rst_x", x_cnt, 0);
        chk("async_rst_frame", frame_cnt, 0);
        chk("async_rst_busy", busy, 0);
        rst_n = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, i);
            tick;
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        tick;
        frame(4, -1);
        chk("post_rst_no_writes", wr_cnt, 0);
        chk("post_rst_idle", busy, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        frame(8, -1);
        chk("post_rst_writes", wr_cnt, 8);
        chk("post_rst_frame", frame_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ccd_fifo_writer.md
# ccd_fifo_writer

Write-side producer for the CCD pixel FIFO consumed by the 3x3 blur stage. Takes the per-pixel RGB stream from the capture/Bayer-to-RGB path, frames it against frame/data-valid strobes, and packs each accepted pixel into the 30-bit `{R,G,B}` word on `CCD_FIFO_IN` with a one-cycle `CCD_FIFO_WE` strobe. It also enforces the active window, counts position and completed frames, and drops the rest of a frame cleanly on FIFO overflow.

## Interface
- `H_ACTIVE`, 640, pixels per line
- `V_ACTIVE`, 480, lines per frame
- `CCD_FIFO_WRCLK` in 1: sole clock, rising edge
- `iRST_N` in 1: reset, asynchronous, active-low
- `iSTART` in 1: one-cycle arm pulse; honoured only in IDLE
- `iCONT` in 1: 1 = re-arm automatically after each frame end; 0 = single frame
- `iFVAL` in 1: frame valid from capture
- `iDVAL` in 1: pixel valid from capture
- `iRed`, `iGreen`, `iBlue` in 10 each: pixel components
- `iFIFO_FULL` in 1: downstream FIFO full, same clock domain
- `CCD_FIFO_WE` out 1: write strobe, one cycle per pixel
- `CCD_FIFO_IN` out 30: `{iRed, iGreen, iBlue}` in bits `[29:20]`, `[19:10]`, `[9:0]`
- `oX_CNT` out 10: column of the next pixel to be accepted
- `oY_CNT` out 9: line of the next pixel to be accepted; saturates at `V_ACTIVE`
- `oFRAME_CNT` out 16: completed frames, wraps modulo 2^16
- `oOVERFLOW` out 1: sticky; a pixel was lost to FIFO full
- `oBUSY` out 1: state ≠ IDLE

## Operation
- Accepted pixel: a cycle with `iFVAL=1 && iDVAL=1` in ACTIVE, with `oY_CNT < V_ACTIVE`.
- FSM states are IDLE, WAIT_SOF, ACTIVE and DROP. Frame start (SOF) is `iFVAL` high this cycle and low the previous cycle, using a registered copy of `iFVAL`. Frame end (EOF) is `iFVAL` low this cycle and high the previous cycle.
- **IDLE:** no writes. `iSTART=1` moves to WAIT_SOF and clears `oOVERFLOW`.
- **WAIT_SOF:** no writes. On SOF, clear `oX_CNT` and `oY_CNT` and go to ACTIVE. The SOF cycle itself is treated as ACTIVE: if `iDVAL=1` on that cycle, the pixel is accepted. Arming in mid-frame (`iFVAL` already high) waits for the next SOF.
- **ACTIVE, accepted pixel with `iFIFO_FULL=0`:**
  - Next cycle: `CCD_FIFO_WE=1` and `CCD_FIFO_IN` carries the packed pixel.
  - `oX_CNT` increments. At `H_ACTIVE-1` it wraps to 0 and `oY_CNT` increments.
- **ACTIVE, accepted pixel with `iFIFO_FULL=1`:** the pixel is not written, `oOVERFLOW` is set, and the FSM goes to DROP.
- **ACTIVE, pixels while `oY_CNT == V_ACTIVE`:** ignored. No write, no counting, no overflow.
- **ACTIVE on EOF:**
  - If `oY_CNT == V_ACTIVE` (complete frame), `oFRAME_CNT` increments. A short frame does not increment it.
  - Next state is WAIT_SOF if `iCONT=1`, otherwise IDLE.
- **DROP:** no writes and counters frozen. On EOF, go to WAIT_SOF if `iCONT=1`, otherwise IDLE. `oFRAME_CNT` does not increment.
- `iFIFO_FULL` is ignored when no pixel is offered.
- `iDVAL` with `iFVAL=0` is ignored in every state.
- `iSTART` outside IDLE is ignored; it does not clear `oOVERFLOW`.

## Timing
- Reset (`iRST_N=0`, asynchronous): state IDLE. `CCD_FIFO_WE=0`, `CCD_FIFO_IN=0`, `oX_CNT=0`, `oY_CNT=0`, `oFRAME_CNT=0`, `oOVERFLOW=0`, `oBUSY=0`, registered `iFVAL=0`.
- Reset mid-frame aborts immediately. After release the block is in IDLE and needs `iSTART` plus a fresh SOF.
- Latency from an accepted pixel to `CCD_FIFO_WE`/`CCD_FIFO_IN` is 1 cycle. Back-to-back pixels give back-to-back writes at full rate.
- `CCD_FIFO_IN` holds the last written word while `CCD_FIFO_WE=0`.
- Counter and flag updates are visible the cycle after the triggering event. `oOVERFLOW` is visible the same cycle the FSM enters DROP.
- `oBUSY` rises the cycle after `iSTART` and falls the cycle after the EOF that ends the frame when `iCONT=0`.
- `iFIFO_FULL` is sampled in the same cycle as the offered pixel. The downstream FIFO must assert full with at least one word of headroom.

## Test plan
- **Single frame:** `iCONT=0`, `H_ACTIVE=4`, `V_ACTIVE=2`, `iSTART`, SOF, 8 pixels with R=G=B=n (n=0..7), EOF.
  - Required: 8 writes with `CCD_FIFO_IN = {n,n,n}`, each 1 cycle after input.
  - Counters go (0,0)…(3,0),(0,1)…(3,1), then `oY_CNT=2`.
  - `oFRAME_CNT=1`, then IDLE with `oBUSY=0`.
- **Mid-frame arm:** `iSTART` while `iFVAL=1` with pixels flowing.
  - Required: zero writes until the next SOF, then a full frame is written.
- **Overflow:** `iFIFO_FULL=1` on pixel 5 of 8.
  - Required: exactly 4 writes, `oOVERFLOW=1`, DROP until EOF.
  - `oFRAME_CNT` unchanged; with `iCONT=1`, the next frame writes all 8.
- **Excess and short frames:** a frame of 10 pixels, then a frame of 5 pixels (`iCONT=1`).
  - Required: first frame writes 8 and ignores 2, `oFRAME_CNT=1`.
  - Second frame writes 5, `oFRAME_CNT` stays 1, `oOVERFLOW=0`.
- **Reset mid-frame:** assert `iRST_N=0` after pixel 3.
  - Required: all outputs zero asynchronously, state IDLE; no writes after release until `iSTART` plus SOF.
- **Stray strobes:** `iDVAL=1` with `iFVAL=0`, and `iSTART` during ACTIVE.
  - Required: no writes, counters unchanged, `oOVERFLOW` unchanged.
